// File: rtl/apu_dmc.sv
// NES APU delta-modulation channel: register decode, sample fetch
// handshake with the DMA engine, rate timer and 7-bit delta DAC.
module apu_dmc (
  input  logic        clk,
  input  logic        rst,
  input  logic        apu_cycle,
  input  logic        reg_wr,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic [7:0]  bus_data_i,
  input  logic        dmc_read,
  output logic        dmc_req,
  output logic        dmc_init,
  output logic        dmc_addr_wr,
  output logic [6:0]  dmc_out,
  output logic        dmc_irq,
  output logic        dmc_active
);

  logic        irq_en;
  logic        loop_en;
  logic [3:0]  rate;
  logic [7:0]  length_reg;
  logic [11:0] bytes_rem;
  logic [7:0]  buffer;
  logic        buf_full;
  logic        req_pending;
  logic        silence;
  logic [2:0]  bits_rem;
  logic [7:0]  shift;
  logic [8:0]  timer;
  logic [8:0]  period_m1;
  logic [6:0]  out_q;
  logic        irq_q;
  logic        init_q;

  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_len;
  logic        wr_stat;
  logic        rd;
  logic        step;
  logic        refill;
  logic [11:0] sample_len;

  assign wr_ctrl     = reg_wr && (cpu_addr_i == 16'h4010);
  assign wr_load     = reg_wr && (cpu_addr_i == 16'h4011);
  assign dmc_addr_wr = reg_wr && (cpu_addr_i == 16'h4012);
  assign wr_len      = reg_wr && (cpu_addr_i == 16'h4013);
  assign wr_stat     = reg_wr && (cpu_addr_i == 16'h4015);

  // A read with no outstanding request (e.g. straddling a reset) is dropped.
  assign rd         = dmc_read && req_pending;
  assign step       = apu_cycle && (timer == 9'd0);
  assign refill     = step && (bits_rem == 3'd1);
  assign sample_len = {length_reg, 4'h0} + 12'd1;

  assign dmc_req    = !buf_full && (bytes_rem != 12'd0)
                      && !req_pending && !init_q;
  assign dmc_init   = init_q;
  assign dmc_out    = out_q;
  assign dmc_irq    = irq_q;
  assign dmc_active = (bytes_rem != 12'd0);

  always_comb begin
    period_m1 = 9'd213;
    unique case (rate)
      4'h0: period_m1 = 9'd213;
      4'h1: period_m1 = 9'd189;
      4'h2: period_m1 = 9'd169;
      4'h3: period_m1 = 9'd159;
      4'h4: period_m1 = 9'd142;
      4'h5: period_m1 = 9'd126;
      4'h6: period_m1 = 9'd112;
      4'h7: period_m1 = 9'd106;
      4'h8: period_m1 = 9'd94;
      4'h9: period_m1 = 9'd79;
      4'ha: period_m1 = 9'd70;
      4'hb: period_m1 = 9'd63;
      4'hc: period_m1 = 9'd52;
      4'hd: period_m1 = 9'd41;
      4'he: period_m1 = 9'd35;
      4'hf: period_m1 = 9'd26;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en      <= 1'b0;
      loop_en     <= 1'b0;
      rate        <= 4'h0;
      length_reg  <= 8'h00;
      bytes_rem   <= 12'd0;
      buffer      <= 8'h00;
      buf_full    <= 1'b0;
      req_pending <= 1'b0;
      silence     <= 1'b1;
      bits_rem    <= 3'd0;
      shift       <= 8'h00;
      timer       <= 9'd213;
      out_q       <= 7'd0;
      irq_q       <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      init_q <= 1'b0;

      if (wr_ctrl) begin
        irq_en  <= cpu_data_i[7];
        loop_en <= cpu_data_i[6];
        rate    <= cpu_data_i[3:0];
      end
      if (wr_len) length_reg <= cpu_data_i;
      if (dmc_req) req_pending <= 1'b1;

      if (apu_cycle) timer <= step ? period_m1 : timer - 9'd1;

      // bits_rem of 0 stands for a full count of 8.
      if (step) begin
        if (!silence) begin
          if (shift[0] && out_q <= 7'd125)
            out_q <= out_q + 7'd2;
          else if (!shift[0] && out_q >= 7'd2)
            out_q <= out_q - 7'd2;
        end
        shift    <= shift >> 1;
        bits_rem <= bits_rem - 3'd1;
        if (refill) begin
          if (buf_full) begin
            shift    <= buffer;
            silence  <= 1'b0;
            buf_full <= 1'b0;
          end else begin
            silence  <= 1'b1;
          end
        end
      end
      if (wr_load) out_q <= cpu_data_i[6:0];

      if (rd) begin
        buffer      <= bus_data_i;
        buf_full    <= 1'b1;
        req_pending <= 1'b0;
      end

      if (wr_stat) begin
        if (!cpu_data_i[4]) begin
          bytes_rem <= 12'd0;
        end else if (bytes_rem == 12'd0) begin
          bytes_rem <= sample_len;
          init_q    <= 1'b1;
        end
      end else if (rd && bytes_rem != 12'd0) begin
        if (bytes_rem == 12'd1) begin
          if (loop_en) begin
            bytes_rem <= sample_len;
            init_q    <= 1'b1;
          end else begin
            bytes_rem <= 12'd0;
            if (irq_en) irq_q <= 1'b1;
          end
        end else begin
          bytes_rem <= bytes_rem - 12'd1;
        end
      end

      if (wr_stat || (wr_ctrl && !cpu_data_i[7])) irq_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apu_dmc.sv
// Directed bench for apu_dmc: fetch handshake, IRQ/loop, clamping,
// rate-timed delta steps and status-write priority.
module tb_apu_dmc;

  logic        clk = 1'b0;
  logic        rst;
  logic        apu_cycle;
  logic        reg_wr;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  bus_data_i;
  logic        dmc_read;
  logic        dmc_req;
  logic        dmc_init;
  logic        dmc_addr_wr;
  logic [6:0]  dmc_out;
  logic        dmc_irq;
  logic        dmc_active;

  apu_dmc dut (
    .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .reg_wr(reg_wr),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .bus_data_i(bus_data_i), .dmc_read(dmc_read),
    .dmc_req(dmc_req), .dmc_init(dmc_init), .dmc_addr_wr(dmc_addr_wr),
    .dmc_out(dmc_out), .dmc_irq(dmc_irq), .dmc_active(dmc_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycnum = 0;
  int last_chg = 0;
  int req_seen = 0;
  bit seen_chg = 0;
  bit mon_en = 0;
  logic [6:0] prev_out;
  logic [6:0] cur_exp;
  logic [6:0] out_q[$];
  bit act_q[$];
  bit irq_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [6:0] e;
    @(posedge clk);
    #1;
    cycnum++;
    reg_wr = 1'b0;
    dmc_read = 1'b0;
    apu_cycle = !apu_cycle;
    if (dmc_req) req_seen++;
    if (mon_en && dmc_out !== prev_out) begin
      if (out_q.size() == 0) begin
        chk("out_hold", 32'(dmc_out), 32'(cur_exp));
      end else begin
        e = out_q.pop_front();
        chk("out_step", 32'(dmc_out), 32'(e));
        if (seen_chg) chk("step_gap", cycnum - last_chg, 54);
        seen_chg = 1;
        last_chg = cycnum;
        cur_exp = e;
      end
    end
    prev_out = dmc_out;
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    reg_wr = 1'b1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cyc();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!dmc_req && n < 3000) begin
      cyc();
      n++;
    end
    chk("req_arrives", 32'(dmc_req), 1);
  endtask

  task automatic serve(logic [7:0] b);
    wait_req();
    cyc();
    chk("req_one_clk", 32'(dmc_req), 0);
    dmc_read = 1'b1;
    bus_data_i = b;
    cyc();
  endtask

  task automatic do_rst();
    mon_en = 0;
    rst = 1'b1;
    #2;
    chk("rst_out", 32'(dmc_out), 0);
    chk("rst_active", 32'(dmc_active), 0);
    chk("rst_irq", 32'(dmc_irq), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    prev_out = dmc_out;
    req_seen = 0;
    seen_chg = 0;
  endtask

  initial begin
    rst = 1'b1;
    apu_cycle = 1'b0;
    reg_wr = 1'b0;
    cpu_addr_i = 16'h0000;
    cpu_data_i = 8'h00;
    bus_data_i = 8'h00;
    dmc_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(dmc_out), 0);
    chk("reset_irq", 32'(dmc_irq), 0);
    chk("reset_req", 32'(dmc_req), 0);
    chk("reset_init", 32'(dmc_init), 0);
    chk("reset_active", 32'(dmc_active), 0);
    reg_wr = 1'b1;
    cpu_addr_i = 16'h4012;
    #1;
    chk("addr_wr_4012", 32'(dmc_addr_wr), 1);
    cpu_addr_i = 16'h4013;
    #1;
    chk("addr_wr_4013", 32'(dmc_addr_wr), 0);
    reg_wr = 1'b0;
    rst = 1'b0;
    cyc();
    prev_out = dmc_out;

    // 17-byte one-shot with IRQ
    wr(16'h4010, 8'h8F);
    wr(16'h4013, 8'h01);
    wr(16'h4015, 8'h10);
    chk("start_init", 32'(dmc_init), 1);
    chk("start_active", 32'(dmc_active), 1);
    cyc();
    chk("init_one_clk", 32'(dmc_init), 0);
    chk("req_after_init", 32'(dmc_req), 1);
    for (int i = 0; i < 17; i++) begin
      act_q.push_back(i < 16);
      irq_q.push_back(i == 16);
      serve(8'(i));
      chk("active_count", 32'(dmc_active), 32'(act_q.pop_front()));
      chk("irq_count", 32'(dmc_irq), 32'(irq_q.pop_front()));
    end
    req_seen = 0;
    repeat (100) cyc();
    chk("no_req_done", req_seen, 0);
    wr(16'h4015, 8'h00);
    chk("irq_cleared", 32'(dmc_irq), 0);

    // looping sample
    do_rst();
    wr(16'h4010, 8'h4F);
    wr(16'h4013, 8'h01);
    wr(16'h4015, 8'h10);
    for (int i = 0; i < 17; i++) begin
      serve(8'h33);
      chk("loop_active", 32'(dmc_active), 1);
    end
    chk("loop_init", 32'(dmc_init), 1);
    chk("loop_no_irq", 32'(dmc_irq), 0);
    cyc();
    chk("loop_init_one", 32'(dmc_init), 0);
    wr(16'h4015, 8'h00);
    chk("loop_stop", 32'(dmc_active), 0);

    // delta steps 66,64,... at rate F
    do_rst();
    wr(16'h4010, 8'h0F);
    wr(16'h4011, 8'h40);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    serve(8'h55);
    cur_exp = 7'd64;
    for (int i = 0; i < 4; i++) begin
      out_q.push_back(7'd66);
      out_q.push_back(7'd64);
    end
    mon_en = 1;
    repeat (1600) cyc();
    mon_en = 0;
    chk("steps_left", out_q.size(), 0);
    chk("steps_final", 32'(dmc_out), 64);

    // clamp high
    do_rst();
    wr(16'h4010, 8'h0F);
    wr(16'h4011, 8'h7E);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    serve(8'hFF);
    cur_exp = 7'd126;
    mon_en = 1;
    repeat (1400) cyc();
    mon_en = 0;
    chk("clamp_high", 32'(dmc_out), 126);

    // clamp low
    do_rst();
    wr(16'h4010, 8'h0F);
    wr(16'h4011, 8'h01);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    serve(8'h00);
    cur_exp = 7'd1;
    mon_en = 1;
    repeat (1400) cyc();
    mon_en = 0;
    chk("clamp_low", 32'(dmc_out), 1);

    // status write racing the read
    do_rst();
    wr(16'h4010, 8'h8F);
    wr(16'h4011, 8'h40);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    wait_req();
    cyc();
    dmc_read = 1'b1;
    bus_data_i = 8'hAA;
    wr(16'h4015, 8'h00);
    chk("race_active", 32'(dmc_active), 0);
    chk("race_irq", 32'(dmc_irq), 0);
    req_seen = 0;
    cur_exp = 7'd64;
    for (int i = 0; i < 4; i++) begin
      out_q.push_back(7'd62);
      out_q.push_back(7'd64);
    end
    mon_en = 1;
    repeat (1600) cyc();
    mon_en = 0;
    chk("race_buffered", out_q.size(), 0);
    chk("race_no_req", req_seen, 0);
    chk("race_irq_late", 32'(dmc_irq), 0);

    // reset during a fetch drops the late read
    do_rst();
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    wait_req();
    cyc();
    do_rst();
    wr(16'h4010, 8'h0F);
    dmc_read = 1'b1;
    bus_data_i = 8'hFF;
    cyc();
    chk("rst_fetch_active", 32'(dmc_active), 0);
    cur_exp = 7'd0;
    mon_en = 1;
    repeat (1400) cyc();
    mon_en = 0;
    chk("rst_fetch_out", 32'(dmc_out), 0);
    chk("rst_fetch_req", req_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apu_dmc.md
APU_DMC -- requirements
Module: apu_dmc

Interface
REQ-001 SHALL have port clk input 1: system clock; one clock domain, all state on its rising edge.
REQ-002 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-003 SHALL have port apu_cycle input 1: one-clk enable pulse, once per APU cycle (every 2nd CPU cycle).
REQ-004 SHALL have port reg_wr input 1: one-clk CPU register write strobe.
REQ-005 SHALL have port cpu_addr_i input 16: CPU address, qualified by reg_wr.
REQ-006 SHALL have port cpu_data_i input 8: CPU write data.
REQ-007 SHALL have port bus_data_i input 8: sample byte from the bus, valid while dmc_read=1.
REQ-008 SHALL have port dmc_read input 1: from the DMA engine; fetched byte is on bus_data_i this cycle.
REQ-009 SHALL have port dmc_req output 1: one-clk pulse requesting a sample fetch.
REQ-010 SHALL have port dmc_init output 1: one-clk pulse telling the DMA engine to reload its sample address from its latch.
REQ-011 SHALL have port dmc_addr_wr output 1: combinational decode of reg_wr at $4012, passed to the DMA engine.
REQ-012 SHALL have port dmc_out output 7: DAC level.
REQ-013 SHALL have port dmc_irq output 1: IRQ flag.
REQ-014 SHALL have port dmc_active output 1: bytes_remaining != 0, for the $4015 status read.

Function
REQ-015 SHALL decode a $4010 write as irq_en=d[7], loop=d[6], rate=d[3:0]; irq_en=0 clears dmc_irq.
REQ-016 SHALL load dmc_out<=d[6:0] on a $4011 write; this write wins over a same-cycle output step.
REQ-017 SHALL store length_reg<=d on a $4013 write; sample length = {length_reg,4'h0}+1 bytes; bytes_remaining is 12 bits.
REQ-018 SHALL clear dmc_irq on any $4015 write.
REQ-019 SHALL act on $4015 d[4]: d[4]=0 sets bytes_remaining=0; d[4]=1 with bytes_remaining==0 loads the sample length and pulses dmc_init; d[4]=1 with bytes_remaining!=0 changes nothing.
REQ-020 SHALL pulse dmc_req for one clk, and set req_pending, when buffer empty, bytes_remaining!=0, req_pending=0 and dmc_init not asserted this cycle.
REQ-021 SHALL, on dmc_read: load buffer<=bus_data_i, set buffer full, clear req_pending, and decrement bytes_remaining if nonzero.
REQ-022 SHALL handle reaching 0 on that decrement: loop=1 reloads the length and pulses dmc_init next cycle; otherwise irq_en=1 sets dmc_irq.
REQ-023 SHALL give a same-cycle $4015 write priority over a dmc_read decrement; the byte is still buffered, with no underflow and no IRQ.
REQ-024 SHALL use a 9-bit rate timer that decrements on apu_cycle; at 0 it reloads period-1 and issues an output step.
REQ-025 SHALL use periods (APU cycles) for rate 0..15 of: 214,190,170,160,143,127,113,107,95,80,71,64,53,42,36,27.
REQ-026 SHALL perform an output step, when not silent: shift[0]=1 and dmc_out<=125 gives +2; shift[0]=0 and dmc_out>=2 gives -2; otherwise hold (no wrap).
REQ-027 SHALL, every output step: shift>>=1 and bits_remaining decrements (3-bit).
REQ-028 SHALL, when bits_remaining reaches 0: reload 8; buffer full loads shift<=buffer, clears silence and empties the buffer; buffer empty sets silence=1.
REQ-029 SHALL, when a refill (REQ-028) and a dmc_read occur in the same cycle, take the old buffer into shift and store the new byte as full.
REQ-030 SHALL keep dmc_req/dmc_init as single-cycle pulses, never asserted on consecutive clks for the same event.

Reset
REQ-031 SHALL on rst: dmc_out=0, dmc_irq=0, dmc_req=0, dmc_init=0, bytes_remaining=0, buffer empty, req_pending=0, silence=1, bits_remaining=8, shift=0, timer=213, rate/loop/irq_en/length_reg=0.
REQ-032 SHALL apply rst mid-fetch immediately: a pending dmc_read after rst release is ignored because req_pending=0.

Verification
REQ-033 SHALL cover: $4013=01, $4015=10 -> dmc_init pulse, bytes_remaining=17, dmc_req next cycle; 17 dmc_reads -> dmc_active falls.
REQ-034 SHALL cover: $4010=80, length 1 (17 bytes), loop=0 -> dmc_irq=1 after 17th read; $4015 write -> dmc_irq=0.
REQ-035 SHALL cover: $4010=4F, loop=1 -> after last byte, dmc_init re-pulses, bytes_remaining=17, no IRQ.
REQ-036 SHALL cover: $4011=7E, byte FF, rate F -> dmc_out holds 126 (clamp); $4011=01, byte 00 -> holds 1.
REQ-037 SHALL cover: $4011=40, byte 55 at rate F -> dmc_out steps 66,64,66,64,... every 27 apu_cycles.
REQ-038 SHALL cover: $4015=00 during req_pending, then dmc_read -> byte buffered, bytes_remaining=0, no IRQ, no new dmc_req.
